// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch/memory bus bundle for the direct-mapped instruction cache
interface icache_dm_if;
    logic [31:0] ifetch;
    logic [31:0] instraddress;
    logic        iready;
    logic [31:0] instruction;
    logic        hit;
    logic        miss;
    logic [31:0] fetchaddr;

    modport master (
        output ifetch, instraddress, iready,
        input  instruction, hit, miss, fetchaddr
    );

    modport slave (
        input  ifetch, instraddress, iready,
        output instruction, hit, miss, fetchaddr
    );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache, one word per line
module icache_dm #(
    parameter int NUM_LINES = 64
) (
    input  logic        clk,
    input  logic        reset,
    icache_dm_if.slave  bus
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic {LOOKUP, REFILL} state_t;

    state_t               state;
    logic [31:2]          miss_addr;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [31:0]          data_array [NUM_LINES];

    logic [INDEX_W-1:0]   cur_index;
    logic [TAG_W-1:0]     cur_tag;
    logic [INDEX_W-1:0]   miss_index;
    logic [TAG_W-1:0]     miss_tag;
    logic                 match;
    logic                 unused_offset;

    assign cur_index  = bus.instraddress[INDEX_W+1:2];
    assign cur_tag    = bus.instraddress[31:INDEX_W+2];
    assign miss_index = miss_addr[INDEX_W+1:2];
    assign miss_tag   = miss_addr[31:INDEX_W+2];
    assign match      = valid[cur_index] && (tag_array[cur_index] == cur_tag);
    // Byte offset never participates in matching.
    assign unused_offset = ^bus.instraddress[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= LOOKUP;
            valid           <= '0;
            miss_addr       <= '0;
            bus.hit         <= 1'b0;
            bus.miss        <= 1'b0;
            bus.instruction <= '0;
            bus.fetchaddr   <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (match) begin
                        bus.hit         <= 1'b1;
                        bus.miss        <= 1'b0;
                        bus.instruction <= data_array[cur_index];
                    end else begin
                        bus.hit       <= 1'b0;
                        bus.miss      <= 1'b1;
                        miss_addr     <= bus.instraddress[31:2];
                        bus.fetchaddr <= {bus.instraddress[31:2], 2'b00};
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    bus.hit <= 1'b0;
                    // Address changes are ignored until the refill lands.
                    if (bus.iready) begin
                        data_array[miss_index] <= bus.ifetch;
                        tag_array[miss_index]  <= miss_tag;
                        valid[miss_index]      <= 1'b1;
                        bus.instruction        <= bus.ifetch;
                        bus.miss               <= 1'b0;
                        state                  <= LOOKUP;
                    end else begin
                        bus.miss <= 1'b1;
                    end
                end
                default: state <= LOOKUP;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - table-driven scoreboard bench for icache_dm
module tb_icache_dm;
    logic clk = 1'b0;
    logic reset;
    icache_dm_if bus ();

    icache_dm #(.NUM_LINES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rdy;
        logic [31:0] fetch;
        logic        e_hit;
        logic        e_miss;
        logic [31:0] e_instr;
        logic [31:0] e_fa;
    } vec_t;

    typedef struct {
        string       name;
        logic        e_hit;
        logic        e_miss;
        logic [31:0] e_instr;
        logic [31:0] e_fa;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] addr, input logic rdy, input logic [31:0] fetch);
        bus.instraddress = addr;
        bus.iready       = rdy;
        bus.ifetch       = fetch;
    endtask

    // Apply one vector for one edge; expectation queued on drive, popped after the edge.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        drive(v.addr, v.rdy, v.fetch);
        sb.push_back('{name, v.e_hit, v.e_miss, v.e_instr, v.e_fa});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".hit"},   {31'd0, bus.hit},  {31'd0, e.e_hit});
        chk({e.name, ".miss"},  {31'd0, bus.miss}, {31'd0, e.e_miss});
        chk({e.name, ".instr"}, bus.instruction,   e.e_instr);
        chk({e.name, ".fa"},    bus.fetchaddr,     e.e_fa);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[18];
    int   hits, misses, wait_cyc;
    logic [31:0] seq_addr [7];

    initial begin
        tbl[0]  = '{32'h08,  1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h08};
        tbl[1]  = '{32'h08,  1'b1, 32'h10000000, 1'b0, 1'b0, 32'h10000000, 32'h08};
        tbl[2]  = '{32'h08,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h08};
        tbl[3]  = '{32'h09,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h08};
        tbl[4]  = '{32'h0B,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h08};
        tbl[5]  = '{32'h0C,  1'b0, 32'h0,        1'b0, 1'b1, 32'h10000000, 32'h0C};
        tbl[6]  = '{32'h0E,  1'b0, 32'h0,        1'b0, 1'b1, 32'h10000000, 32'h0C};
        tbl[7]  = '{32'h0E,  1'b1, 32'h10000004, 1'b0, 1'b0, 32'h10000004, 32'h0C};
        tbl[8]  = '{32'h0E,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000004, 32'h0C};
        tbl[9]  = '{32'h08,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h0C};
        tbl[10] = '{32'h108, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10000000, 32'h108};
        tbl[11] = '{32'h108, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 32'h108};
        tbl[12] = '{32'h108, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 32'h108};
        tbl[13] = '{32'h08,  1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 32'h08};
        tbl[14] = '{32'h08,  1'b1, 32'h10000000, 1'b0, 1'b0, 32'h10000000, 32'h08};
        tbl[15] = '{32'h08,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h08};
        tbl[16] = '{32'h08,  1'b1, 32'h00000BAD, 1'b1, 1'b0, 32'h10000000, 32'h08};
        tbl[17] = '{32'h0A,  1'b0, 32'h0,        1'b1, 1'b0, 32'h10000000, 32'h08};

        do_reset();
        chk("reset.hit",   {31'd0, bus.hit},  32'd0);
        chk("reset.miss",  {31'd0, bus.miss}, 32'd0);
        chk("reset.instr", bus.instruction,   32'd0);
        chk("reset.fa",    bus.fetchaddr,     32'd0);

        for (int i = 0; i < 18; i++) step($sformatf("vec%0d", i), tbl[i]);

        // Reset mid-refill: abort, then previously valid 0x0C misses.
        step("rr_miss", '{32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10000000, 32'h200});
        reset = 1'b1;
        drive(32'h200, 1'b1, 32'h55555555);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rr.hit",   {31'd0, bus.hit},  32'd0);
        chk("rr.miss",  {31'd0, bus.miss}, 32'd0);
        chk("rr.instr", bus.instruction,   32'd0);
        step("rr_0c", '{32'h0C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0C});
        step("rr_fill", '{32'h0C, 1'b1, 32'h10000004, 1'b0, 1'b0, 32'h10000004, 32'h0C});
        step("rr_200", '{32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10000004, 32'h200});
        step("rr_fill2", '{32'h200, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h200});

        // Seven-access hit/miss tally from a cold cache.
        do_reset();
        seq_addr = '{32'h08, 32'h08, 32'h09, 32'h0B, 32'h0C, 32'h0E, 32'h0E};
        hits = 0;
        misses = 0;
        for (int i = 0; i < 7; i++) begin
            drive(seq_addr[i], 1'b0, 32'h0);
            @(posedge clk);
            #1;
            if (bus.hit) hits++;
            else if (bus.miss) begin
                misses++;
                drive(seq_addr[i], 1'b1, 32'h10000000 + {seq_addr[i][31:2], 2'b00} - 32'h8);
                @(posedge clk);
                #1;
                drive(seq_addr[i], 1'b0, 32'h0);
                wait_cyc = 0;
                while (!bus.hit && wait_cyc < 8) begin
                    @(posedge clk);
                    #1;
                    wait_cyc++;
                end
                chk($sformatf("seq%0d.refill_hit", i), {31'd0, bus.hit}, 32'd1);
            end
        end
        chk("seq.misses", misses, 32'd2);
        chk("seq.hits",   hits,   32'd5);
        step("seq_final", '{32'h0E, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10000004, 32'h0C});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core fetch stage and instruction memory.
- Each line holds one 32-bit word plus tag and valid bit; byte offset is addr[1:0].
- Lookups are registered. A miss issues a word-aligned fetch address and waits for memory to return the word (ifetch qualified by iready), then writes the line.

Parameters:
- NUM_LINES, 64, number of lines (power of 2). INDEX_W = log2(NUM_LINES).
- Address split: offset = addr[1:0]; index = addr[INDEX_W+1:2]; tag = addr[31:INDEX_W+2].

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ifetch  in  32  instruction word returned by memory; valid when iready=1
- instraddress  in  32  byte address requested by the core
- iready  in  1  memory data-valid strobe for ifetch
- instruction  out  32  cached instruction word for the current address
- hit  out  1  registered: the last lookup hit
- miss  out  1  registered: a miss is outstanding
- fetchaddr  out  32  word-aligned refill address {miss_addr[31:2],2'b00}

Behaviour:
- Reset (synchronous, active-high): clear all valid bits; state=LOOKUP; hit=0, miss=0, instruction=0, fetchaddr=0. Tag and data arrays need not be cleared. Reset during REFILL aborts the refill with no array write.
- Combinational match = valid[index] && tag_array[index]==tag(instraddress).
- LOOKUP state, every rising edge:
  - match=1: hit<=1, miss<=0, instruction<=data[index]; stay in LOOKUP.
  - match=0: hit<=0, miss<=1; latch miss_addr<=instraddress; fetchaddr<={instraddress[31:2],2'b00}; go to REFILL.
- REFILL state:
  - hit=0, miss=1; fetchaddr held.
  - Changes to instraddress are ignored.
  - iready=0: stay in REFILL.
  - iready=1 at a rising edge: data[idx(miss_addr)]<=ifetch, tag<=tag(miss_addr), valid<=1; instruction<=ifetch; miss<=0, hit<=0; go to LOOKUP.
  - The next LOOKUP edge re-evaluates and reports hit=1 for the same address.
- Latency:
  - Hit: result visible one edge after the address is presented; stable while the address is held.
  - Miss: miss=1 one edge after the address; fill completes on the edge where iready=1; hit one edge later.
- Offset bits are ignored for matching: all four byte addresses of a word hit the same line.
- Conflict: a different tag at the same index misses; refill overwrites the line (no associativity).
- iready while in LOOKUP: ignored.
- Outputs hold their values between updates. fetchaddr keeps its last miss address after the refill.

Test Plan:
- Reset, then addr 0x00000008 → miss=1 after 1 edge, fetchaddr=0x00000008. Pulse iready=1 with ifetch=0x10000000 → miss=0; next lookup hit=1, instruction=0x10000000.
- Addresses 0x08, 0x09, 0x0B after that fill → hit=1 each, instruction=0x10000000, miss=0.
- Addr 0x0000000C (cold) → miss=1, fetchaddr=0x0000000C. Fill ifetch=0x10000004 → 0x0E then hits with instruction=0x10000004.
- 7-access sequence 08,08,09,0B,0C,0E,0E → 2 misses, 5 hits (hit rate 71.43%).
- Conflict: fill 0x08, then 0x108 (same index, NUM_LINES=64) → miss. After fill, 0x08 misses again.
- Reset asserted mid-REFILL → miss=0, hit=0; the previously valid line now misses. iready asserted in LOOKUP with no miss → no array change.
